// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter that multiplexes NREQ write requesters onto the two register-file
// write ports, holding writes that would collide with the core's own r28/r31 updates.
module regfile_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int addrsize = 5,
  parameter int MAXWAIT  = 15,
  parameter bit ZERO_R0  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*addrsize-1:0] req_addr,
  input  logic [NREQ*32-1:0]       req_data,
  output logic [NREQ-1:0]          gnt,
  input  logic                     stwr_next,
  input  logic                     pcincr_next,
  output logic [addrsize-1:0]      wa0,
  output logic [addrsize-1:0]      wa1,
  output logic [31:0]              wd0,
  output logic [31:0]              wd1,
  output logic [1:0]               write,
  output logic [NREQ-1:0]          starve,
  output logic                     busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [addrsize-1:0] ST_ADDR = addrsize'(28);
  localparam logic [addrsize-1:0] PC_ADDR = addrsize'(31);
  localparam logic [7:0]          WAIT_LIM = 8'(MAXWAIT);

  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] elig;
  logic            s0_vld, s1_vld;
  logic [PW-1:0]   s0_idx, s1_idx;
  logic [PW-1:0]   rr_next;
  logic [7:0]      cnt [NREQ];

  function automatic logic [addrsize-1:0] addr_of(input logic [PW-1:0] i);
    return req_addr[int'(i)*addrsize +: addrsize];
  endfunction

  function automatic logic [31:0] data_of(input logic [PW-1:0] i);
    return req_data[int'(i)*32 +: 32];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic wr_en(input logic [addrsize-1:0] a);
    return !(ZERO_R0 && (a == '0));
  endfunction

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req[i]
             && !((addr_of(PW'(i)) == ST_ADDR) && stwr_next)
             && !((addr_of(PW'(i)) == PC_ADDR) && pcincr_next);
    end
  end

  // Walk requesters in rotated order; slot 1 must target a different register than slot 0.
  always_comb begin
    logic [PW-1:0] ix;
    s0_vld = 1'b0;
    s1_vld = 1'b0;
    s0_idx = '0;
    s1_idx = '0;
    ix     = '0;
    for (int k = 0; k < NREQ; k++) begin
      ix = PW'((int'(rr_ptr) + k) % NREQ);
      if (elig[ix]) begin
        if (!s0_vld) begin
          s0_vld = 1'b1;
          s0_idx = ix;
        end else if (!s1_vld && (addr_of(ix) != addr_of(s0_idx))) begin
          s1_vld = 1'b1;
          s1_idx = ix;
        end
      end
    end
    rr_next = PW'((int'(s1_vld ? s1_idx : s0_idx) + 1) % NREQ);
  end

  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (s0_vld) gnt[s0_idx] = 1'b1;
      if (s1_vld) gnt[s1_idx] = 1'b1;
    end
  end

  assign busy = |(req & ~gnt);

  // Registered write ports: address/data hold when a slot is unused
  always_ff @(posedge clk) begin
    if (rst) begin
      write  <= 2'b00;
      wa0    <= '0;
      wa1    <= '0;
      wd0    <= '0;
      wd1    <= '0;
      rr_ptr <= '0;
    end else begin
      write[0] <= s0_vld && wr_en(addr_of(s0_idx));
      write[1] <= s1_vld && wr_en(addr_of(s1_idx));
      if (s0_vld) begin
        wa0 <= addr_of(s0_idx);
        wd0 <= data_of(s0_idx);
      end
      if (s1_vld) begin
        wa1 <= addr_of(s1_idx);
        wd1 <= data_of(s1_idx);
      end
      if (s0_vld) rr_ptr <= rr_next;
    end
  end

  // starve follows the counter value before this edge, but drops together with the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] || !req[i]) begin
          cnt[i]    <= '0;
          starve[i] <= 1'b0;
        end else begin
          cnt[i]    <= sat_inc(cnt[i]);
          starve[i] <= (cnt[i] >= WAIT_LIM);
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: expected port writes are queued when a cycle is
// driven and compared after the following clock edge; a shadow register file tracks updates.
module tb_regfile_wr_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 5;
  localparam int MAXWAIT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [AW-1:0]     a [NREQ];
  logic [31:0]       d [NREQ];
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              stwr_next, pcincr_next;
  logic [AW-1:0]     wa0, wa1;
  logic [31:0]       wd0, wd1;
  logic [1:0]        write;
  logic [NREQ-1:0]   starve;
  logic              busy;

  typedef struct {
    logic [1:0]    wr;
    logic          all;
    logic [AW-1:0] wa0;
    logic [AW-1:0] wa1;
    logic [31:0]   wd0;
    logic [31:0]   wd1;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] rf  [32];
  int          nvec = 0;
  int          nmis = 0;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_addr[g*AW +: AW] = a[g];
    assign req_data[g*32 +: 32] = d[g];
  end

  regfile_wr_arbiter #(.NREQ(NREQ), .addrsize(AW), .MAXWAIT(MAXWAIT), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .stwr_next(stwr_next), .pcincr_next(pcincr_next),
    .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1), .write(write),
    .starve(starve), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check comb outputs, queue the expected port write, then compare after the edge
  task automatic step(input logic [3:0] eg, input logic eb, input logic [1:0] ew,
                      input logic [AW-1:0] ea0, input logic [31:0] ed0,
                      input logic [AW-1:0] ea1, input logic [31:0] ed1,
                      input logic [3:0] es, input logic eall = 1'b0);
    exp_t e, o;
    #1;
    check("gnt", 64'(gnt), 64'(eg));
    check("busy", 64'(busy), 64'(eb));
    e.wr = ew; e.all = eall; e.wa0 = ea0; e.wa1 = ea1; e.wd0 = ed0; e.wd1 = ed1;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    o = sbq.pop_front();
    check("write", 64'(write), 64'(o.wr));
    if (o.wr[0] || o.all) begin
      check("wa0", 64'(wa0), 64'(o.wa0));
      check("wd0", 64'(wd0), 64'(o.wd0));
    end
    if (o.wr[1] || o.all) begin
      check("wa1", 64'(wa1), 64'(o.wa1));
      check("wd1", 64'(wd1), 64'(o.wd1));
    end
    check("dupaddr", 64'((write == 2'b11) && (wa0 == wa1)), 64'(0));
    check("starve", 64'(starve), 64'(es));
    if (write[0] === 1'b1) rf[wa0] = wd0;
    if (write[1] === 1'b1) rf[wa1] = wd1;
  endtask

  task automatic set_sc2(input logic [31:0] base);
    for (int i = 0; i < NREQ; i++) begin
      a[i] = AW'(3 + i);
      d[i] = base + 32'(i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1'b1; stwr_next = 1'b0; pcincr_next = 1'b0;
    req = 4'b1111;
    set_sc2(32'h1111_0000);

    // reset held two cycles with all requesters asserted
    step(4'b0000, 1'b1, 2'b00, '0, '0, '0, '0, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 2'b00, '0, '0, '0, '0, 4'b0000, 1'b1);

    // round-robin, two grants per cycle, pointer advances past last grant
    rst = 1'b0;
    step(4'b0011, 1'b1, 2'b11, 5'd3, 32'h1111_0000, 5'd4, 32'h1111_0001, 4'b0000);
    req = 4'b1100;
    step(4'b1100, 1'b0, 2'b11, 5'd5, 32'h1111_0002, 5'd6, 32'h1111_0003, 4'b0000);
    req = 4'b0000;
    step(4'b0000, 1'b0, 2'b00, '0, '0, '0, '0, 4'b0000);

    // same-address requests serialise in priority order
    a[0] = 5'd7; d[0] = 32'hAAAA_0007;
    a[1] = 5'd7; d[1] = 32'hBBBB_0007;
    req = 4'b0011;
    step(4'b0001, 1'b1, 2'b01, 5'd7, 32'hAAAA_0007, '0, '0, 4'b0000);
    req = 4'b0010;
    step(4'b0010, 1'b0, 2'b01, 5'd7, 32'hBBBB_0007, '0, '0, 4'b0000);
    req = 4'b0000;
    step(4'b0000, 1'b0, 2'b00, '0, '0, '0, '0, 4'b0000);
    check("r7_final", 64'(rf[7]), 64'(32'hBBBB_0007));

    // r31 blocked by pcincr_next; starvation flag rises then clears after the grant
    a[0] = 5'd31; d[0] = 32'hC0DE_001F;
    req = 4'b0001; pcincr_next = 1'b1;
    for (int j = 0; j < 20; j++)
      step(4'b0000, 1'b1, 2'b00, '0, '0, '0, '0, (j >= MAXWAIT) ? 4'b0001 : 4'b0000);
    pcincr_next = 1'b0;
    step(4'b0001, 1'b0, 2'b01, 5'd31, 32'hC0DE_001F, '0, '0, 4'b0000);
    req = 4'b0000;
    step(4'b0000, 1'b0, 2'b00, '0, '0, '0, '0, 4'b0000);

    // write to r0 is granted but dropped
    a[2] = 5'd0; d[2] = 32'hDEAD_BEEF;
    req = 4'b0100;
    step(4'b0100, 1'b0, 2'b00, '0, '0, '0, '0, 4'b0000);
    req = 4'b0000;
    step(4'b0000, 1'b0, 2'b00, '0, '0, '0, '0, 4'b0000);
    check("r0_zero", 64'(rf[0]), 64'(0));

    // reset in the grant cycle discards the grants and restores rr_ptr=0
    set_sc2(32'h2222_0000);
    req = 4'b1111; rst = 1'b1;
    step(4'b0000, 1'b1, 2'b00, '0, '0, '0, '0, 4'b0000, 1'b1);
    rst = 1'b0; req = 4'b0000;
    step(4'b0000, 1'b0, 2'b00, '0, '0, '0, '0, 4'b0000);
    check("r3_kept", 64'(rf[3]), 64'(32'h1111_0000));
    req = 4'b1111;
    step(4'b0011, 1'b1, 2'b11, 5'd3, 32'h2222_0000, 5'd4, 32'h2222_0001, 4'b0000);
    req = 4'b1100;
    step(4'b1100, 1'b0, 2'b11, 5'd5, 32'h2222_0002, 5'd6, 32'h2222_0003, 4'b0000);
    req = 4'b0000;
    step(4'b0000, 1'b0, 2'b00, '0, '0, '0, '0, 4'b0000);

    // both r28 and r31 blocked at once; other addresses proceed
    a[0] = 5'd28; d[0] = 32'h5555_001C;
    a[1] = 5'd31; d[1] = 32'h6666_001F;
    a[2] = 5'd9;  d[2] = 32'h7777_0009;
    req = 4'b0111; stwr_next = 1'b1; pcincr_next = 1'b1;
    step(4'b0100, 1'b1, 2'b01, 5'd9, 32'h7777_0009, '0, '0, 4'b0000);
    req = 4'b0011; stwr_next = 1'b0; pcincr_next = 1'b0;
    step(4'b0011, 1'b0, 2'b11, 5'd28, 32'h5555_001C, 5'd31, 32'h6666_001F, 4'b0000);
    req = 4'b0000;
    step(4'b0000, 1'b0, 2'b00, '0, '0, '0, '0, 4'b0000);
    check("r9_final", 64'(rf[9]), 64'(32'h7777_0009));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
